// File: rtl/muldiv_arbiter.sv
// muldiv_arbiter: round-robin front end that shares one sequential
// multiply/divide unit among NREQ requesters, one operation in flight.
// The winner's operands are latched, the unit gets a one-cycle start, the
// unit_ready low->high sequence is tracked, and the result is returned
// tagged with the requester id.
// Optional build macro MULDIV_ARB_TIMEOUT_EN adds a watchdog that forces a
// zero result with timeout_err after TIMEOUT_CYCLES cycles of waiting.
module muldiv_arbiter #(
  parameter int NREQ           = 4,
  parameter int W              = 32,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_m_d,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_m_d,
  output logic [2*W-1:0]      rsp_data,
  output logic                unit_start,
  output logic                unit_m_d,
  output logic [W-1:0]        unit_a,
  output logic [W-1:0]        unit_b,
  input  logic                unit_ready,
  input  logic [2*W-1:0]      unit_result
`ifdef MULDIV_ARB_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP} state_t;

  // Illegal parameter combinations land in this empty marker block.
  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || TIMEOUT_CYCLES < 1) begin : g_bad_params
  end

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic             m_d_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [2*W-1:0]   data_reg;

  logic             found;
  logic [IDW-1:0]   win_id;
  logic             take;
  logic             capture;
  logic             expire;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    int cand;
    found  = 1'b0;
    win_id = '0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found  = 1'b1;
        win_id = IDW'(cand);
      end
    end
  end

`ifdef MULDIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_reg;
  logic          to_reg;

  // Watchdog fires while waiting unless a genuine result arrives this cycle.
  always_comb begin
    expire = 1'b0;
    if ((state_reg == WAIT_LO || state_reg == WAIT_HI) &&
        !(state_reg == WAIT_HI && unit_ready) &&
        (cnt_reg >= CW'(TIMEOUT_CYCLES - 1)))
      expire = 1'b1;
  end

  // Wait counter: cleared when an op is issued, counts only in the wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      to_reg  <= 1'b0;
    end else begin
      if (take)
        cnt_reg <= '0;
      else if (state_reg == WAIT_LO || state_reg == WAIT_HI)
        cnt_reg <= cnt_reg + 1'b1;
      if (capture)
        to_reg <= 1'b0;
      else if (expire)
        to_reg <= 1'b1;
    end
  end

  assign timeout_err = (state_reg == RESP) && to_reg;
`else
  assign expire = 1'b0;
`endif

  // Next-state and grant logic; gnt is only offered while idle and out of reset.
  always_comb begin
    state_next = state_reg;
    gnt        = '0;
    take       = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!reset && unit_ready && found) begin
          gnt[win_id] = 1'b1;
          take        = 1'b1;
          state_next  = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT_LO;
      WAIT_LO: begin
        if (expire)          state_next = RESP;
        else if (!unit_ready) state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (unit_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (expire) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, pointer, latched operands and captured result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      m_d_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        id_reg  <= win_id;
        m_d_reg <= req_m_d[win_id];
        a_reg   <= req_a[win_id*W +: W];
        b_reg   <= req_b[win_id*W +: W];
        ptr_reg <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
      if (capture)
        data_reg <= unit_result;
      else if (expire)
        data_reg <= '0;
    end
  end

  assign busy       = (state_reg != IDLE);
  assign unit_start = (state_reg == ISSUE);
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_id     = id_reg;
  assign rsp_m_d    = m_d_reg;
  assign rsp_data   = data_reg;
  assign unit_m_d   = m_d_reg;
  assign unit_a     = a_reg;
  assign unit_b     = b_reg;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb_muldiv_arbiter: directed bench for muldiv_arbiter with a behavioural
// 1+64 cycle multiply/divide unit. Cycle 0 is the grant cycle of each op.
module tb_muldiv_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, req_m_d;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   gnt;
  logic              busy, rsp_valid, rsp_m_d;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic              unit_start, unit_m_d;
  logic [W-1:0]      unit_a, unit_b;
  logic              unit_ready;
  logic [2*W-1:0]    unit_result;
`ifdef MULDIV_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  int tests = 0;
  int fails = 0;

  muldiv_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .TIMEOUT_CYCLES(128)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_m_d(req_m_d), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_m_d(rsp_m_d), .rsp_data(rsp_data),
    .unit_start(unit_start), .unit_m_d(unit_m_d), .unit_a(unit_a), .unit_b(unit_b),
    .unit_ready(unit_ready), .unit_result(unit_result)
`ifdef MULDIV_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural unit: one load cycle plus 64 op cycles of ready low.
  logic [6:0]     ucnt;
  logic [2*W-1:0] ures;
  logic           stuck;
  always @(posedge clk) begin
    if (reset) begin
      ucnt <= '0;
      ures <= '0;
    end else if (unit_start && !stuck) begin
      ucnt <= 7'd65;
      ures <= unit_m_d ? ({32'd0, unit_a} * {32'd0, unit_b})
                       : {unit_a % unit_b, unit_a / unit_b};
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 1'b1;
    end
  end
  assign unit_ready  = (ucnt == 0);
  assign unit_result = ures;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    req_m_d[i]     = m;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Called in cycle 1; advances until rsp_valid, watching for stray activity.
  task automatic wait_rsp(input logic [W-1:0] a0, input logic [W-1:0] b0,
                          output int at, output bit stray_gnt,
                          output bit ab_moved, output bit stray_start);
    int n;
    n = 1; at = -1; stray_gnt = 0; ab_moved = 0; stray_start = 0;
    while (at < 0 && n < 300) begin
      cyc();
      n++;
      if (gnt != 0) stray_gnt = 1;
      if (unit_start) stray_start = 1;
      if (unit_a !== a0 || unit_b !== b0) ab_moved = 1;
      if (rsp_valid) at = n;
    end
  endtask

  initial begin
    int at, nrsp;
    bit sg, am, ss;
    reset = 1'b1; req = '0; req_m_d = '0; req_a = '0; req_b = '0; stuck = 1'b0;
    repeat (3) cyc();
    check("reset_gnt", gnt, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_unit_start", unit_start, 0);
    check("reset_unit_a", unit_a, 0);
`ifdef MULDIV_ARB_TIMEOUT_EN
    check("reset_timeout_err", timeout_err, 0);
`endif
    reset = 1'b0;
    cyc();

    // Round robin: req 0 and 2 together from reset -> 0 then 2.
    set_op(0, 1'b1, 32'd3, 32'd5);
    set_op(2, 1'b1, 32'd4, 32'd4);
    req = 4'b0101; #1;
    check("rr1_gnt0", gnt, 4'b0001);
    cyc(); req = 4'b0100; #1;
    check("rr1_start", unit_start, 1);
    check("rr1_busy", busy, 1);
    check("rr1_unit_a", unit_a, 3);
    wait_rsp(32'd3, 32'd5, at, sg, am, ss);
    check("rr1_rsp_cycle", at, 68);
    check("rr1_holdoff_no_gnt", sg, 0);
    check("rr1_data", rsp_data, 15);
    check("rr1_id", rsp_id, 0);
    cyc();
    check("rr1_gnt2_cycle69", gnt, 4'b0100);
    cyc(); req = 4'b0000; #1;
    check("rr1b_unit_a", unit_a, 4);
    wait_rsp(32'd4, 32'd4, at, sg, am, ss);
    check("rr1b_rsp_cycle", at, 68);
    check("rr1b_data", rsp_data, 16);
    check("rr1b_id", rsp_id, 2);
    cyc();
    check("rr1b_idle", busy, 0);

    // Pointer at 3: req 0 and 3 -> 3 then 0 (3 is a divide).
    set_op(3, 1'b0, 32'd50, 32'd6);
    set_op(0, 1'b1, 32'd9, 32'd9);
    req = 4'b1001; #1;
    check("rr2_gnt3", gnt, 4'b1000);
    cyc(); req = 4'b0001; #1;
    check("rr2_unit_m_d", unit_m_d, 0);
    wait_rsp(32'd50, 32'd6, at, sg, am, ss);
    check("rr2_data", rsp_data, {32'd2, 32'd8});
    check("rr2_m_d", rsp_m_d, 0);
    check("rr2_id", rsp_id, 3);
    cyc();
    check("rr2_gnt0", gnt, 4'b0001);
    cyc(); req = 4'b0000; #1;
    wait_rsp(32'd9, 32'd9, at, sg, am, ss);
    check("rr2b_data", rsp_data, 81);
    check("rr2b_id", rsp_id, 0);
    cyc();

    // Single op with hold-off of req 2 raised while busy.
    set_op(1, 1'b1, 32'd7, 32'd6);
    req = 4'b0010; #1;
    check("single_gnt1", gnt, 4'b0010);
    cyc();
    set_op(2, 1'b1, 32'h0001_0000, 32'h0001_0000);
    req = 4'b0100; #1;
    check("single_start", unit_start, 1);
    check("single_unit_m_d", unit_m_d, 1);
    wait_rsp(32'd7, 32'd6, at, sg, am, ss);
    check("single_rsp_cycle", at, 68);
    check("hold_no_gnt_busy", sg, 0);
    check("hold_ab_stable", am, 0);
    check("single_one_start", ss, 0);
    check("single_data", rsp_data, 42);
    check("single_id", rsp_id, 1);
    check("single_m_d", rsp_m_d, 1);
    cyc();
    check("hold_gnt2_cycle69", gnt, 4'b0100);
    cyc(); req = 4'b0000; #1;
    wait_rsp(32'h0001_0000, 32'h0001_0000, at, sg, am, ss);
    check("wide_mul_data", rsp_data, 64'h0000_0001_0000_0000);
    cyc();
    check("after_wide_rsp_valid", rsp_valid, 0);

    // Divide from requester 0 (pointer wraps 3 -> 0).
    set_op(0, 1'b0, 32'd100, 32'd7);
    req = 4'b0001; #1;
    check("div_gnt0", gnt, 4'b0001);
    cyc(); req = 4'b0000; #1;
    wait_rsp(32'd100, 32'd7, at, sg, am, ss);
    check("div_data", rsp_data, {32'd2, 32'd14});
    check("div_m_d", rsp_m_d, 0);
    check("div_id", rsp_id, 0);
    cyc();

    // Reset mid-operation at cycle 30.
    set_op(2, 1'b1, 32'd5, 32'd5);
    req = 4'b0100; #1;
    check("rst_gnt2", gnt, 4'b0100);
    cyc(); req = 4'b0000;
    repeat (28) cyc();
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    check("rst_busy", busy, 0);
    check("rst_unit_start", unit_start, 0);
    nrsp = 0;
    repeat (80) begin
      cyc();
      if (rsp_valid) nrsp++;
    end
    check("rst_no_rsp", nrsp, 0);
    set_op(3, 1'b1, 32'd11, 32'd3);
    set_op(0, 1'b1, 32'd2, 32'd2);
    req = 4'b1001; #1;
    check("rst_ptr0_gnt0", gnt, 4'b0001);
    cyc(); req = 4'b1000; #1;
    wait_rsp(32'd2, 32'd2, at, sg, am, ss);
    check("rst_op0_data", rsp_data, 4);
    cyc();
    check("rst_gnt3", gnt, 4'b1000);
    cyc(); req = 4'b0000; #1;
    wait_rsp(32'd11, 32'd3, at, sg, am, ss);
    check("rst_op3_cycle", at, 68);
    check("rst_op3_data", rsp_data, 33);
    check("rst_op3_id", rsp_id, 3);
    cyc();

`ifdef MULDIV_ARB_TIMEOUT_EN
    // Unit never drops ready: watchdog returns zero with timeout_err.
    stuck = 1'b1;
    set_op(1, 1'b1, 32'd3, 32'd3);
    req = 4'b0010; #1;
    check("to_gnt1", gnt, 4'b0010);
    cyc(); req = 4'b0000; #1;
    wait_rsp(32'd3, 32'd3, at, sg, am, ss);
    check("to_rsp_cycle", at, 130);
    check("to_err", timeout_err, 1);
    check("to_data", rsp_data, 0);
    cyc();
    check("to_err_pulse", timeout_err, 0);
    stuck = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Shares one sequential multiply/divide unit (64-cycle shift-and-add/subtract core with start/ready handshake) among NREQ requesters.
- Round-robin arbitration; one operation in flight.
- Latches the winner's operands and op select, issues a one-cycle start, tracks the unit's ready low→high sequence, returns the result tagged with requester id.
- Sits between client pipelines and the mul/div unit controller.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 32, operand width
- IDW, 2, requester id width, equals clog2(NREQ)
- TIMEOUT_CYCLES, 128, watchdog limit (used only with the optional feature)

Ports:
- clk, input, 1, clock
- reset, input, 1, synchronous active-high reset
- req, input, NREQ, per-requester request; held until gnt
- req_m_d, input, NREQ, per-requester op: 1 = multiply, 0 = divide
- req_a, input, NREQ*W, packed operand A, slice i = requester i
- req_b, input, NREQ*W, packed operand B
- gnt, output, NREQ, one-hot one-cycle accept pulse
- busy, output, 1, high in any state other than IDLE
- rsp_valid, output, 1, one-cycle result pulse
- rsp_id, output, IDW, requester that owns rsp_data
- rsp_m_d, output, 1, op of the returned result
- rsp_data, output, 2*W, registered unit result
- unit_start, output, 1, start pulse to mul/div unit
- unit_m_d, output, 1, op select to unit, held during op
- unit_a, output, W, latched operand A
- unit_b, output, W, latched operand B
- unit_ready, input, 1, unit idle flag
- unit_result, input, 2*W, unit result, valid when unit_ready returns high

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 0, latched operands 0, id 0.
- Reset mid-operation: abandons the op, no rsp_valid; the unit shares the same reset.
- FSM:
  - IDLE: if unit_ready=1 and any req, pick the first requester at or after the rr pointer (wrapping). Assert gnt[i] this cycle. At the clock edge, latch req_a[i], req_b[i], req_m_d[i] and i; set pointer to (i+1) mod NREQ; go to ISSUE. If unit_ready=0 or no req, stay with no gnt.
  - ISSUE: unit_start=1 for exactly one cycle, then go to WAIT_LO.
  - WAIT_LO: wait for unit_ready=0, then go to WAIT_HI.
  - WAIT_HI: wait for unit_ready=1; at that edge capture unit_result into rsp_data, then go to RESP.
  - RESP: rsp_valid=1 for one cycle with rsp_id and rsp_m_d, then go to IDLE.
- Latency, with the unit running 1 load cycle + 64 op cycles:
  - gnt in cycle 0, unit_start in cycle 1
  - unit_ready low cycles 2..66, high in cycle 67
  - rsp_valid in cycle 68
  - next gnt no earlier than cycle 69
- Outputs unit_m_d, unit_a, unit_b are stable from ISSUE through WAIT_HI. rsp_data holds its value until the next capture.
- A requester dropping req before gnt receives no gnt; the pointer does not move.
- req arriving while busy=1 is held off with no gnt until IDLE.
- Simultaneous requests: strict rotation. With all four asserted continuously, grant order is 0,1,2,3,0.
- unit_start is never asserted unless the FSM left IDLE with unit_ready=1.
- Without the optional feature, WAIT_LO and WAIT_HI wait indefinitely.

Optional Feature:
- Macro: MULDIV_ARB_TIMEOUT_EN.
- Enabled:
  - Adds output timeout_err, 1 bit, reset 0.
  - Adds a cycle counter, cleared on entry to ISSUE and incremented in WAIT_LO and WAIT_HI.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to RESP with rsp_data=0 and timeout_err=1 pulsed together with rsp_valid.
- Disabled: no port, no counter, behaviour exactly as above.

Test Plan:
- Single op: req[1]=1, m_d=1, a=7, b=6 → gnt[1] cycle 0, unit_start cycle 1, rsp_valid cycle 68, rsp_id=1, rsp_m_d=1, rsp_data=42.
- Round robin: req[0], req[2] held from reset → served in order 0 then 2. Then req[0], req[3] → served in order 3 then 0 (pointer=3 after serving 2).
- Hold-off: req[2] asserted while busy → no gnt until IDLE; gnt[2] at cycle 69; operands from the first op unchanged on unit_a/unit_b through cycle 67.
- Divide: req[0], m_d=0, a=100, b=7 → rsp_data = {remainder 2, quotient 14} in the unit's packing; rsp_m_d=0.
- Reset mid-op: reset at cycle 30 → no rsp_valid, busy=0, pointer 0. A new req[3] after reset is granted normally.
- Timeout (macro on): unit_ready stuck 1 after start, TIMEOUT_CYCLES=128 → rsp_valid and timeout_err pulse 128 cycles after ISSUE exit, rsp_data=0.
